// File: rtl/iobus_periph.sv
// Memory-mapped I/O block for a small MCU: synchronized switches, LED register,
// compare/match timer with interrupt, and an 8N1 UART transmitter fed by a byte FIFO.
module iobus_periph #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  input  logic [15:0] SWITCHES,
  output logic [15:0] LEDS,
  output logic        UART_TXD,
  output logic        INTR
);

  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LED    = 32'h1100_0020;
  localparam logic [31:0] A_TCNT   = 32'h1100_0040;
  localparam logic [31:0] A_TCMP   = 32'h1100_0044;
  localparam logic [31:0] A_TCTRL  = 32'h1100_0048;
  localparam logic [31:0] A_TXDATA = 32'h1100_0060;
  localparam logic [31:0] A_TXSTAT = 32'h1100_0064;

  localparam int          PW        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [4:0]  FIFO_CAP  = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic [15:0]   sw_meta_q, sw_sync_q, leds_q;
  logic [31:0]   tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic          en_q, en_d, ie_q, ie_d, pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q;
  tx_state_e     state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic wr_led, wr_tcnt, wr_tcmp, wr_tctrl, wr_tx, wr_txstat;
  logic fifo_full, fifo_empty, push, pop, baud_end, timer_match;

  assign wr_led    = IOBUS_WR && (IOBUS_ADDR == A_LED);
  assign wr_tcnt   = IOBUS_WR && (IOBUS_ADDR == A_TCNT);
  assign wr_tcmp   = IOBUS_WR && (IOBUS_ADDR == A_TCMP);
  assign wr_tctrl  = IOBUS_WR && (IOBUS_ADDR == A_TCTRL);
  assign wr_tx     = IOBUS_WR && (IOBUS_ADDR == A_TXDATA);
  assign wr_txstat = IOBUS_WR && (IOBUS_ADDR == A_TXSTAT);

  assign fifo_full   = (count_q == FIFO_CAP);
  assign fifo_empty  = (count_q == 5'd0);
  assign push        = wr_tx && !fifo_full;
  assign baud_end    = (baud_q == BAUD_LAST);
  // The FSM takes the next byte either from IDLE or at the last STOP cycle.
  assign pop         = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign timer_match = en_q && (tcnt_q == tcmp_q);

  always_comb begin
    tcnt_d = tcnt_q;
    if (wr_tcnt)          tcnt_d = IOBUS_OUT;
    else if (timer_match) tcnt_d = 32'd0;
    else if (en_q)        tcnt_d = tcnt_q + 32'd1;
    tcmp_d = wr_tcmp  ? IOBUS_OUT    : tcmp_q;
    en_d   = wr_tctrl ? IOBUS_OUT[0] : en_q;
    ie_d   = wr_tctrl ? IOBUS_OUT[1] : ie_q;
    pend_d = pend_q;
    if (timer_match)                    pend_d = 1'b1;
    else if (wr_tctrl && IOBUS_OUT[2])  pend_d = 1'b0;
    ovf_d = ovf_q;
    if (wr_tx && fifo_full)             ovf_d = 1'b1;
    else if (wr_txstat && IOBUS_OUT[3]) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
      leds_q    <= 16'd0;
      tcnt_q    <= 32'd0;
      tcmp_q    <= 32'hFFFF_FFFF;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
      if (wr_led) leds_q <= IOBUS_OUT[15:0];
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 5'd1;
      else if (pop && !push) count_q <= count_q - 5'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          state_q <= START;
          shift_q <= fifo_q[rd_ptr_q];
          txd_q   <= 1'b0;
          baud_q  <= 16'd0;
        end
        START: if (baud_end) begin
          state_q <= DATA;
          baud_q  <= 16'd0;
          bit_q   <= 3'd0;
          txd_q   <= shift_q[0];
        end else baud_q <= baud_q + 16'd1;
        DATA: if (baud_end) begin
          baud_q <= 16'd0;
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= shift_q >> 1;
            txd_q   <= shift_q[1];
          end
        end else baud_q <= baud_q + 16'd1;
        STOP: if (baud_end) begin
          baud_q <= 16'd0;
          if (pop) begin
            state_q <= START;
            shift_q <= fifo_q[rd_ptr_q];
            txd_q   <= 1'b0;
          end else state_q <= IDLE;
        end else baud_q <= baud_q + 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    IOBUS_IN = 32'd0;
    case (IOBUS_ADDR)
      A_SW:     IOBUS_IN = {16'd0, sw_sync_q};
      A_LED:    IOBUS_IN = {16'd0, leds_q};
      A_TCNT:   IOBUS_IN = tcnt_q;
      A_TCMP:   IOBUS_IN = tcmp_q;
      A_TCTRL:  IOBUS_IN = {29'd0, pend_q, ie_q, en_q};
      A_TXSTAT: IOBUS_IN = {23'd0, count_q, ovf_q, (state_q != IDLE), fifo_empty, fifo_full};
      default:  IOBUS_IN = 32'd0;
    endcase
  end

  assign LEDS     = leds_q;
  assign UART_TXD = txd_q;
  assign INTR     = pend_q & ie_q;

endmodule

// File: tb/tb_iobus_periph.sv
// Randomized self-checking bench for iobus_periph; expectations come from a
// behavioural model of the register map, timer rules and UART framing.
`timescale 1ns/1ps
module tb_iobus_periph;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_SW     = 32'h1100_0000;
  localparam logic [31:0] A_LED    = 32'h1100_0020;
  localparam logic [31:0] A_TCNT   = 32'h1100_0040;
  localparam logic [31:0] A_TCMP   = 32'h1100_0044;
  localparam logic [31:0] A_TCTRL  = 32'h1100_0048;
  localparam logic [31:0] A_TXDATA = 32'h1100_0060;
  localparam logic [31:0] A_TXSTAT = 32'h1100_0064;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES = 16'd0;
  logic [15:0] LEDS;
  logic        UART_TXD;
  logic        INTR;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  iobus_periph #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES), .LEDS(LEDS),
    .UART_TXD(UART_TXD), .INTR(INTR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_WR = 1'b0;
    #1;
    d = IOBUS_IN;
  endtask

  // Line level of an 8N1 frame, i cycles after the start bit begins.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int slot;
    slot = i / BAUD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    SWITCHES = 16'($urandom_range(1, 16'hFFFF));
    RESET = 1'b0;
    repeat (3) tick();
    total++; if (LEDS !== 16'd0) begin bad++; $display("FAIL reset_leds: got %h want 0000", LEDS); end
    total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", UART_TXD); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", INTR); end
    bus_read(A_SW, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_sw: got %h want 0", d); end
    bus_read(A_TCNT, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_tcnt: got %h want 0", d); end
    bus_read(A_TCMP, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_tcmp: got %h want ffffffff", d); end
    bus_read(A_TCTRL, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_tctrl: got %h want 0", d); end
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL reset_txstat: got %h want 2", d); end
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_led();
    logic [31:0] d, v, a;
    logic [15:0] led_m;
    logic [31:0] junk [4];
    junk[0] = 32'h1100_0021; junk[1] = 32'h1100_0024; junk[2] = 32'h0100_0020; junk[3] = A_SW;
    bus_write(A_LED, 32'hDEAD_BEEF);
    led_m = 16'hBEEF;
    total++; if (LEDS !== led_m) begin bad++; $display("FAIL led_pins: got %h want %h", LEDS, led_m); end
    bus_read(A_LED, d);
    total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL led_read: got %h want 0000beef", d); end
    bus_read(32'h1100_0004, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_read: got %h want 0", d); end
    bus_read(A_TXDATA, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL txdata_read: got %h want 0", d); end
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a = A_LED;
        led_m = v[15:0];
      end else begin
        a = junk[$urandom_range(0, 3)];
      end
      bus_write(a, v);
      total++; if (LEDS !== led_m) begin bad++; $display("FAIL led_rand_pins: addr %h got %h want %h", a, LEDS, led_m); end
      bus_read(A_LED, d);
      total++; if (d !== {16'd0, led_m}) begin bad++; $display("FAIL led_rand_read: got %h want %h", d, {16'd0, led_m}); end
    end
  endtask

  task automatic test_switches();
    logic [31:0] d;
    logic [15:0] old, v;
    SWITCHES = 16'd0;
    repeat (3) tick();
    old = 16'd0;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 16'h1234 : 16'($urandom);
      SWITCHES = v;
      bus_read(A_SW, d);
      total++; if (d !== {16'd0, old}) begin bad++; $display("FAIL sw_lag0: got %h want %h", d, {16'd0, old}); end
      tick();
      bus_read(A_SW, d);
      total++; if (d !== {16'd0, old}) begin bad++; $display("FAIL sw_lag1: got %h want %h", d, {16'd0, old}); end
      tick();
      bus_read(A_SW, d);
      total++; if (d !== {16'd0, v}) begin bad++; $display("FAIL sw_sync: got %h want %h", d, {16'd0, v}); end
      old = v;
    end
  endtask

  task automatic test_timer(input int c, input int n);
    logic [31:0] d, cnt_m, v;
    logic pend_m, match, w1c, tw, tdone;
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TCTRL, 32'h4);
    bus_write(A_TCNT, 32'h0);
    bus_write(A_TCMP, 32'(c));
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL timer_pre_intr: got %b want 0", INTR); end
    bus_write(A_TCTRL, 32'h3);
    cnt_m = 32'd0; pend_m = 1'b0; tdone = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus_read(A_TCNT, d);
      total++; if (d !== cnt_m) begin bad++; $display("FAIL timer_cnt c=%0d k=%0d: got %0d want %0d", c, k, d, cnt_m); end
      total++; if (INTR !== pend_m) begin bad++; $display("FAIL timer_intr c=%0d k=%0d: got %b want %b", c, k, INTR, pend_m); end
      tw  = !tdone && (k >= 18) && (cnt_m == 32'(c));
      w1c = !tw && ((k == 9) || (k == 15) || ((k >= c + 2) && ($urandom_range(0, 4) == 0)));
      v   = 32'($urandom_range(0, c));
      if (tw) begin
        IOBUS_ADDR = A_TCNT; IOBUS_OUT = v; IOBUS_WR = 1'b1; tdone = 1'b1;
      end else if (w1c) begin
        IOBUS_ADDR = A_TCTRL; IOBUS_OUT = 32'h7; IOBUS_WR = 1'b1;
      end
      tick();
      IOBUS_WR = 1'b0;
      match  = (cnt_m == 32'(c));
      pend_m = match | (pend_m & !w1c);
      if (tw)         cnt_m = v;
      else if (match) cnt_m = 32'd0;
      else            cnt_m = cnt_m + 32'd1;
    end
    bus_write(A_TCTRL, 32'h0);
    bus_write(A_TCTRL, 32'h4);
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL timer_off_intr: got %b want 0", INTR); end
  endtask

  task automatic test_uart_frame(input logic [7:0] b);
    logic [31:0] d;
    logic e;
    bus_write(A_TXDATA, {$urandom, b} >> 0 & 32'hFFFF_FF00 | {24'd0, b});
    total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL frame_pre: got %b want 1", UART_TXD); end
    for (int i = 0; i < 10 * BAUD; i++) begin
      tick();
      e = frame_bit(b, i);
      total++; if (UART_TXD !== e) begin bad++; $display("FAIL frame_bit b=%h i=%0d: got %b want %b", b, i, UART_TXD, e); end
      bus_read(A_TXSTAT, d);
      total++; if (d[2] !== 1'b1) begin bad++; $display("FAIL frame_busy i=%0d: got %b want 1", i, d[2]); end
    end
    tick();
    total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL frame_idle_txd: got %b want 1", UART_TXD); end
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL frame_idle_stat: got %h want 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic stream [$];
    logic [31:0] d, exp;
    for (int j = 0; j < 6; j++) bytes[j] = 8'($urandom);
    for (int f = 0; f < DEPTH + 1; f++)
      for (int i = 0; i < 10 * BAUD; i++) stream.push_back(frame_bit(bytes[f], i));
    for (int j = 0; j < 6; j++) begin
      IOBUS_ADDR = A_TXDATA; IOBUS_OUT = {24'd0, bytes[j]}; IOBUS_WR = 1'b1;
      tick();
      if (j >= 1) begin
        total++; if (UART_TXD !== stream[j-1]) begin bad++; $display("FAIL b2b_early i=%0d: got %b want %b", j - 1, UART_TXD, stream[j-1]); end
      end
    end
    IOBUS_WR = 1'b0;
    exp = {23'd0, 5'(DEPTH), 1'b1, 1'b1, 1'b0, 1'b1};
    bus_read(A_TXSTAT, d);
    total++; if (d !== exp) begin bad++; $display("FAIL b2b_full_stat: got %h want %h", d, exp); end
    for (int idx = 5; idx < stream.size(); idx++) begin
      tick();
      total++; if (UART_TXD !== stream[idx]) begin bad++; $display("FAIL b2b_bit i=%0d: got %b want %b", idx, UART_TXD, stream[idx]); end
      if (idx % (10 * BAUD) == 0) begin
        bus_read(A_TXSTAT, d);
        total++; if (d[8:4] !== 5'(DEPTH - idx / (10 * BAUD))) begin bad++; $display("FAIL b2b_count i=%0d: got %0d want %0d", idx, d[8:4], DEPTH - idx / (10 * BAUD)); end
      end
    end
    for (int i = 0; i < 2 * BAUD; i++) begin
      tick();
      total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL b2b_tail: got %b want 1", UART_TXD); end
    end
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'hA) begin bad++; $display("FAIL b2b_ovf_stat: got %h want a", d); end
    bus_write(A_TXSTAT, 32'h8);
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL b2b_ovf_clr: got %h want 2", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [31:0] d;
    b = 8'($urandom) & 8'hF7;
    bus_write(A_TXDATA, {24'd0, b});
    repeat (1 + 4 * BAUD + 1) tick();
    total++; if (UART_TXD !== 1'b0) begin bad++; $display("FAIL mid_bit3: got %b want 0", UART_TXD); end
    #2;
    RESET = 1'b0;
    #1;
    total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL mid_rst_txd: got %b want 1", UART_TXD); end
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL mid_rst_stat: got %h want 2", d); end
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 12 * BAUD; i++) begin
      tick();
      total++; if (UART_TXD !== 1'b1) begin bad++; $display("FAIL mid_quiet i=%0d: got %b want 1", i, UART_TXD); end
    end
    bus_read(A_TXSTAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL mid_quiet_stat: got %h want 2", d); end
    bus_write(A_TXDATA, 32'h0000_00FF);
    tick();
    total++; if (UART_TXD !== 1'b0) begin bad++; $display("FAIL mid_restart: got %b want 0", UART_TXD); end
    repeat (10 * BAUD + 2) tick();
  endtask

  initial begin
    test_reset();
    test_led();
    test_switches();
    test_timer(3, 24);
    test_timer(0, 22);
    test_timer($urandom_range(1, 6), 32);
    test_uart_frame(8'hA5);
    test_uart_frame(8'($urandom));
    test_uart_frame(8'($urandom));
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/iobus_periph.md
IOBUS_PERIPH -- requirements
Module: iobus_periph

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning UART TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IOBUS_ADDR  input  32  byte address from the MCU memory stage.
REQ-006 SHALL have port IOBUS_OUT  input  32  write data from the MCU.
REQ-007 SHALL have port IOBUS_WR  input  1  write strobe, one cycle per store.
REQ-008 SHALL have port IOBUS_IN  output  32  read data to the MCU.
REQ-009 SHALL have port SWITCHES  input  16  asynchronous board switches.
REQ-010 SHALL have port LEDS  output  16  LED register.
REQ-011 SHALL have port UART_TXD  output  1  serial 8N1 line, idle high.
REQ-012 SHALL have port INTR  output  1  level interrupt to the MCU.

Function
REQ-013 SHALL decode on an exact 32-bit match: 0x11000000 SW (RO), 0x11000020 LED (RW), 0x11000040 TCNT (RW), 0x11000044 TCMP (RW), 0x11000048 TCTRL (RW), 0x11000060 TXDATA (WO), 0x11000064 TXSTAT (RW).
REQ-014 SHALL drive IOBUS_IN combinationally from IOBUS_ADDR in the same cycle, with no read side effects; unmapped and write-only addresses read 0.
REQ-015 SHALL commit writes at the rising CLK when IOBUS_WR=1; writes to unmapped or read-only addresses are ignored.
REQ-016 SHALL pass SWITCHES through a two-flop synchronizer; the SW read value is zero-extended and lags the pins by 2 cycles.
REQ-017 SHALL load LEDS from IOBUS_OUT[15:0] on an LED write; a LED read returns {16'b0, LEDS}.
REQ-018 SHALL define TCTRL fields: bit0 EN, bit1 IE, bit2 PEND. A write sets EN and IE from data, and writing 1 to bit2 clears PEND (W1C).
REQ-019 SHALL advance TCNT by 1 per cycle while EN=1 (32-bit wrap); when EN=1 and TCNT==TCMP, TCNT SHALL become 0 on the next edge and PEND SHALL become 1.
REQ-020 SHALL give a TCNT write priority over increment and match-clear in the same cycle; TCMP=0 with EN=1 matches every cycle.
REQ-021 SHALL give the match set of PEND priority over a simultaneous W1C.
REQ-022 SHALL drive INTR = PEND & IE, registered-state only, with no combinational path from IOBUS inputs.
REQ-023 SHALL push IOBUS_OUT[7:0] into the TX FIFO on a TXDATA write when the FIFO is not full. When full, judged on the pre-edge count even if a pop occurs in the same cycle, the byte SHALL be dropped and OVF set.
REQ-024 SHALL define TXSTAT fields: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF (sticky, W1C), bits[8:4] entry count.
REQ-025 SHALL run a TX FSM with states IDLE, START, DATA, STOP, with UART_TXD registered.
REQ-026 SHALL, in IDLE with the FIFO non-empty, pop one byte and enter START on the same edge.
REQ-027 SHALL hold each bit for exactly BAUD_DIV cycles: START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
REQ-028 SHALL, at the end of STOP, enter START directly (popping the next byte) if the FIFO is non-empty, else IDLE; a gapless frame is 10*BAUD_DIV cycles.
REQ-029 SHALL allow a push and a pop in the same cycle when not full, leaving the count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, while RESET=0 and asynchronously: LEDS=0, TCNT=0, TCMP=0xFFFFFFFF, TCTRL=0, OVF=0, FIFO empty, FSM IDLE, baud and bit counters 0, UART_TXD=1, INTR=0, synchronizer flops 0.
REQ-031 SHALL, on reset mid-frame, abort the frame and return UART_TXD high immediately, with no partial byte resumed after release.

Verification
REQ-032 Bench SHALL cover: write LED 0xDEADBEEF -> LEDS=0xBEEF next cycle; read LED -> 0x0000BEEF; read 0x11000004 -> 0.
REQ-033 Bench SHALL cover: TCMP=3, TCTRL=0x3 -> TCNT sequence 0,1,2,3,0; INTR rises the cycle after TCNT=3 and holds; write TCTRL 0x7 -> INTR falls next cycle unless a match coincides.
REQ-034 Bench SHALL cover: BAUD_DIV=4, write TXDATA 0xA5 -> UART_TXD 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1; BUSY=1 throughout, 40 cycles total.
REQ-035 Bench SHALL cover: BAUD_DIV=4, FIFO_DEPTH=4, 6 back-to-back TXDATA writes while idle -> 5 bytes sent (1 popped immediately, 4 queued), 6th dropped, OVF=1, frames gapless; writing TXSTAT 0x8 -> OVF=0.
REQ-036 Bench SHALL cover: SWITCHES 0x0000->0x1234 -> SW read 0 for 2 cycles, then 0x00001234.
REQ-037 Bench SHALL cover: RESET low during DATA bit 3 -> UART_TXD=1 and TXSTAT=0x2 immediately; after release, no transmission until the next write.
